down_timer: RTL

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/down_timer.sv | 117 +++++++++++
 1 files changed

// File: rtl/down_timer.sv
// Programmable down-counter with one-shot / auto-reload modes, pause and abort.
// count, tick, busy and done are all registered.
module down_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             periodic,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tick,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] reload_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             mode;
   logic             mode_nxt;
   logic             tick_nxt;
   logic             busy_nxt;
   logic             done_nxt;

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         reload <= '0;
         mode   <= 1'b0;
         count  <= '0;
         tick   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         reload <= reload_nxt;
         mode   <= mode_nxt;
         count  <= count_nxt;
         tick   <= tick_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
      end
   end

   // Next-state logic; abort outranks start, pause and expiry
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (abort)      state_nxt = S_IDLE;
            else if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (abort)               state_nxt = S_IDLE;
            else if (count == '0)    state_nxt = mode ? S_RUN : S_DONE;
            else if (pause)          state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (abort)       state_nxt = S_IDLE;
            else if (!pause) state_nxt = S_RUN;
         end
         S_DONE: begin
            if (abort)      state_nxt = S_IDLE;
            else if (start) state_nxt = S_RUN;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      reload_nxt = load ? load_val : reload;
      mode_nxt   = mode;
      count_nxt  = count;

      if ((state == S_IDLE || state == S_DONE) && start && !abort)
         mode_nxt = periodic;

      unique case (state)
         S_IDLE: count_nxt = reload_nxt;
         S_RUN: begin
            if (abort)            count_nxt = reload_nxt;
            else if (count == '0) count_nxt = mode ? reload : '0;
            else if (!pause)      count_nxt = count - WIDTH'(1);
         end
         // Leaving HOLD decrements at once, so the tick slips by exactly the paused cycles
         S_HOLD: begin
            if (abort)       count_nxt = reload_nxt;
            else if (!pause) count_nxt = count - WIDTH'(1);
         end
         S_DONE: begin
            if (abort || start) count_nxt = reload_nxt;
            else                count_nxt = '0;
         end
         default: count_nxt = '0;
      endcase

      tick_nxt = (state_nxt == S_RUN) && (count_nxt == '0);
      busy_nxt = (state_nxt == S_RUN) || (state_nxt == S_HOLD);
      done_nxt = (state_nxt == S_DONE);
   end

endmodule
